fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction fetch stage directly upstream of the single-cycle execute/PC-select datapath.
- Owns the fetch PC and issues word requests to instruction memory over a valid/ready request channel with in-order, variable-latency responses.
- Buffers returned words in a small FIFO and presents {instruction, pc} to the consumer with valid/ready.
- Accepts redirects (taken JAL/branch target from the PC-select logic), flushes queued words and discards in-flight responses.

Parameters:
DEPTH, 2, FIFO entries and maximum outstanding requests (power of two, 2..8)
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous reset, active-low (asserted when 0)
redirect_valid  in  1  load new fetch target this cycle
redirect_pc  in  32  new fetch target (byte address)
mem_req_valid  out  1  request present
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  32  word-aligned byte address of request
mem_resp_valid  in  1  response word present, in request order, never back-pressured
mem_resp_data  in  32  instruction word
instr_valid  out  1  FIFO head valid
instr_ready  in  1  consumer takes head
instr_out  out  32  head instruction
instr_pc  out  32  byte address of head instruction

Behaviour:
- Reset (reset==0 at a clock edge):
  - fetch_pc=RESET_PC, FIFO empty, outstanding=0, state=BOOT.
  - mem_req_valid=0, instr_valid=0, instr_out=0, instr_pc=0.
- Register layout: each FIFO entry stores {data, pc}. outstanding counts accepted but unreturned requests (width clog2(DEPTH)+1).
- FSM:
  - BOOT: one idle cycle, then RUN. A redirect in BOOT sets fetch_pc.
  - RUN: mem_req_valid=1 iff outstanding+fifo_count < DEPTH.
    - mem_req_addr=fetch_pc.
    - On req handshake: fetch_pc+=4 (wraps modulo 2^32), outstanding+=1.
    - On response: push {mem_resp_data, pc_tag}, outstanding-=1. pc_tag comes from a parallel tag FIFO of issued addresses, depth DEPTH.
    - Credit rule guarantees the FIFO never overflows.
  - FLUSH: mem_req_valid=0. Responses are dropped and decrement outstanding. When outstanding reaches 0 (including the cycle a response arrives with outstanding==1), next state is RUN.
- Redirect (any state):
  - FIFO and tag FIFO cleared same edge; fetch_pc=redirect_pc with [1:0] forced 0.
  - A response arriving in the same cycle is discarded.
  - A request handshake in the same cycle counts as outstanding and will be discarded.
  - Next state: FLUSH if the resulting outstanding>0, else RUN.
  - A redirect during FLUSH updates the target and stays in FLUSH.
  - A consumer pop in the same cycle is void: nothing is delivered twice or retained.
- Output timing:
  - instr_valid/instr_out/instr_pc come from registered FIFO head.
  - Minimum latency from response to instr_valid is 1 cycle.
  - instr_valid=0 in the cycle after a redirect.
- Simultaneous push and pop in RUN: both occur, count unchanged. Push to empty FIFO with pop is not bypassed.
- Outputs hold while instr_valid && !instr_ready.
- mem_req_addr is stable while mem_req_valid && !mem_req_ready, unless a redirect occurs.
- Reset mid-operation discards everything. Responses to pre-reset requests are the memory model's responsibility to cancel (memory shares the same reset).

Optional Feature:
- Macro FETCH_MISALIGN_TRAP_EN.
- Defined:
  - Adds output misaligned_fault (1 bit, reset 0).
  - A redirect with redirect_pc[1:0]!=0 sets misaligned_fault=1, latches the raw address on output fault_pc[31:0], and enters state HALT.
  - HALT issues no requests, still drains/discards responses, and exits only on reset or a new aligned redirect, which clears the fault.
- Undefined: ports absent; the low two bits are silently cleared as above.

Test Plan:
- Reset release, memory ready=1, latency 1, consumer ready=1 -> requests at 0x0,0x4,0x8...; instr_pc sequence 0x0,0x4,0x8 with matching data; first instr_valid at cycle 3 after reset deassertion.
- Consumer ready=0 for 10 cycles, DEPTH=2 -> exactly 2 requests accepted, mem_req_valid=0 afterwards, head stays {word@0x0, 0x0}.
- Memory latency 3 with 2 outstanding, redirect to 0x40 -> both stale responses discarded, next request 0x40 issued only after outstanding==0, first delivered instr_pc=0x40.
- Redirect in same cycle as response and consumer pop -> no word delivered from old stream; instr_valid=0 next cycle.
- fetch_pc=0xFFFF_FFFC -> next request address 0x0000_0000.
- With FETCH_MISALIGN_TRAP_EN, redirect to 0x42 -> misaligned_fault=1, fault_pc=0x42, no requests. Then redirect to 0x80 -> fault cleared, fetch resumes at 0x80.

Source files
------------

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: groups the redirect, memory request/response and
// instruction delivery signals of the fetch stage.
// master = fetch_queue side, slave = surrounding datapath / memory side.
// With FETCH_MISALIGN_TRAP_EN defined the misaligned-redirect fault
// outputs are added.
interface fetch_queue_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misaligned_fault;
    logic [31:0] fault_pc;

    modport master (
        input  redirect_valid, redirect_pc,
        output mem_req_valid, mem_req_addr,
        input  mem_req_ready,
        input  mem_resp_valid, mem_resp_data,
        output instr_valid, instr_out, instr_pc,
        input  instr_ready,
        output misaligned_fault, fault_pc
    );

    modport slave (
        output redirect_valid, redirect_pc,
        input  mem_req_valid, mem_req_addr,
        output mem_req_ready,
        output mem_resp_valid, mem_resp_data,
        input  instr_valid, instr_out, instr_pc,
        output instr_ready,
        input  misaligned_fault, fault_pc
    );
`else
    modport master (
        input  redirect_valid, redirect_pc,
        output mem_req_valid, mem_req_addr,
        input  mem_req_ready,
        input  mem_resp_valid, mem_resp_data,
        output instr_valid, instr_out, instr_pc,
        input  instr_ready
    );

    modport slave (
        output redirect_valid, redirect_pc,
        input  mem_req_valid, mem_req_addr,
        output mem_req_ready,
        output mem_resp_valid, mem_resp_data,
        input  instr_valid, instr_out, instr_pc,
        output instr_ready
    );
`endif
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch stage. Owns the fetch PC, issues in-order
// word requests, buffers returned words with their PCs in a DEPTH-entry
// FIFO and hands {instruction, pc} to the execute stage. Redirects flush
// the queue and drop responses still in flight.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (trap on misaligned
// redirect targets instead of silently clearing the low address bits).
module fetch_queue #(
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset,
    fetch_queue_if.master bus
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = CW + 1;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] out_q, out_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW-1:0] twr_q, twr_d, trd_q, trd_d;
    logic          req_valid_q, req_valid_d;
    logic          instr_valid_q, instr_valid_d;
    logic [31:0]   instr_out_q, instr_out_d;
    logic [31:0]   instr_pc_q, instr_pc_d;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic          fault_q, fault_d;
    logic [31:0]   fault_pc_q, fault_pc_d;
`endif

    // Instruction FIFO ({data, pc}) and tag FIFO of issued addresses.
    logic [31:0]   data_mem [DEPTH];
    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   tag_mem  [DEPTH];

    logic          req_fire;
    logic          resp_fire;
    logic          push;
    logic          pop;
    logic [SW-1:0] credit_used;

    // Next-state logic: FSM, counters, pointers and the registered head.
    always_comb begin
        req_fire   = req_valid_q & bus.mem_req_ready;
        // A response can only exist for an accepted request.
        resp_fire  = bus.mem_resp_valid & (out_q != '0);
        push       = 1'b0;
        pop        = 1'b0;
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        // In-flight bookkeeping holds in every state, including the
        // redirect cycle: a request accepted now is still owed a response.
        out_d      = out_q + CW'(req_fire) - CW'(resp_fire);
        cnt_d      = cnt_q;
        wr_d       = wr_q;
        rd_d       = rd_q;
        twr_d      = twr_q;
        trd_d      = trd_q;
`ifdef FETCH_MISALIGN_TRAP_EN
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;
`endif

        if (bus.redirect_valid) begin
            // Old stream is void: queued words, tags and any pop this cycle.
            cnt_d = '0;
            wr_d  = '0;
            rd_d  = '0;
            twr_d = '0;
            trd_d = '0;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (bus.redirect_pc[1:0] != 2'b00) begin
                state_d    = HALT;
                fault_d    = 1'b1;
                fault_pc_d = bus.redirect_pc;
            end else begin
                fault_d    = 1'b0;
                fetch_pc_d = bus.redirect_pc & ~32'h3;
                state_d    = (out_d != '0) ? FLUSH : RUN;
            end
`else
            fetch_pc_d = bus.redirect_pc & ~32'h3;
            state_d    = (out_d != '0) ? FLUSH : RUN;
`endif
        end else begin
            case (state_q)
                BOOT: state_d = RUN;
                RUN: begin
                    if (req_fire) begin
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        twr_d      = twr_q + AW'(1);
                    end
                    if (resp_fire) begin
                        push  = 1'b1;
                        wr_d  = wr_q + AW'(1);
                        trd_d = trd_q + AW'(1);
                    end
                    pop = instr_valid_q & bus.instr_ready;
                    if (pop) begin
                        rd_d = rd_q + AW'(1);
                    end
                    cnt_d = cnt_q + CW'(push) - CW'(pop);
                end
                FLUSH: begin
                    if (out_d == '0) begin
                        state_d = RUN;
                    end
                end
                default: state_d = state_q;
            endcase
        end

        // Credit rule: never more words owed plus buffered than FIFO slots.
        credit_used   = SW'(out_d) + SW'(cnt_d);
        req_valid_d   = (state_d == RUN) && (credit_used < SW'(DEPTH));
        instr_valid_d = (cnt_d != '0);

        // Head after this edge: the word being written if it lands at the
        // read pointer (FIFO empty after any pop), otherwise stored entry.
        instr_out_d = '0;
        instr_pc_d  = '0;
        if (cnt_d != '0) begin
            if (push && (wr_q == rd_d)) begin
                instr_out_d = bus.mem_resp_data;
                instr_pc_d  = tag_mem[trd_q];
            end else begin
                instr_out_d = data_mem[rd_d];
                instr_pc_d  = pc_mem[rd_d];
            end
        end
    end

    // Control and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= BOOT;
            fetch_pc_q    <= RESET_PC;
            out_q         <= '0;
            cnt_q         <= '0;
            wr_q          <= '0;
            rd_q          <= '0;
            twr_q         <= '0;
            trd_q         <= '0;
            req_valid_q   <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_out_q   <= '0;
            instr_pc_q    <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
            fault_q       <= 1'b0;
            fault_pc_q    <= '0;
`endif
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            out_q         <= out_d;
            cnt_q         <= cnt_d;
            wr_q          <= wr_d;
            rd_q          <= rd_d;
            twr_q         <= twr_d;
            trd_q         <= trd_d;
            req_valid_q   <= req_valid_d;
            instr_valid_q <= instr_valid_d;
            instr_out_q   <= instr_out_d;
            instr_pc_q    <= instr_pc_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            fault_q       <= fault_d;
            fault_pc_q    <= fault_pc_d;
`endif
        end
    end

    // FIFO payload storage; validity is tracked by the pointers above.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_q] <= bus.mem_resp_data;
            pc_mem[wr_q]   <= tag_mem[trd_q];
        end
        if (req_fire) begin
            tag_mem[twr_q] <= fetch_pc_q;
        end
    end

    assign bus.mem_req_valid = req_valid_q;
    assign bus.mem_req_addr  = fetch_pc_q;
    assign bus.instr_valid   = instr_valid_q;
    assign bus.instr_out     = instr_out_q;
    assign bus.instr_pc      = instr_pc_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign bus.misaligned_fault = fault_q;
    assign bus.fault_pc         = fault_pc_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed bench for fetch_queue (DEPTH=2) with an
// in-order variable-latency memory model and a delivery log.
module tb_fetch_queue;

    logic clk = 1'b0;
    logic reset;

    fetch_queue_if bus();

    fetch_queue #(.DEPTH(2), .RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    typedef struct {
        logic [31:0] start;
        int          lat;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    mreq_t       mq[$];
    logic [31:0] req_addr_log[$];
    int          req_cyc_log[$];
    int          resp_cyc_log[$];
    logic [31:0] del_pc[$];
    logic [31:0] del_data[$];
    vec_t        vecs[4];

    int cyc      = 0;
    int lat      = 1;
    int n_checks = 0;
    int n_errors = 0;

    function automatic logic [31:0] wordf(input logic [31:0] a);
        return a ^ 32'h5A5A_F00D;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic clear_logs();
        req_addr_log.delete();
        req_cyc_log.delete();
        resp_cyc_log.delete();
        del_pc.delete();
        del_data.delete();
    endtask

    // One clock: observe handshakes before the edge, update the memory
    // model after it, then present the next response.
    task automatic tick();
        logic        fire_req;
        logic        fire_resp;
        logic        fire_pop;
        logic        rst_now;
        logic [31:0] a;
        logic [31:0] ppc;
        logic [31:0] pdat;
        rst_now   = reset;
        fire_req  = bus.mem_req_valid && bus.mem_req_ready;
        a         = bus.mem_req_addr;
        fire_resp = bus.mem_resp_valid;
        fire_pop  = bus.instr_valid && bus.instr_ready && !bus.redirect_valid;
        ppc       = bus.instr_pc;
        pdat      = bus.instr_out;
        @(posedge clk);
        cyc++;
        if (!rst_now) begin
            mq.delete();
        end else begin
            if (fire_resp && mq.size() > 0) begin
                void'(mq.pop_front());
                resp_cyc_log.push_back(cyc);
            end
            if (fire_req) begin
                mq.push_back('{addr: a, due: cyc + lat});
                req_addr_log.push_back(a);
                req_cyc_log.push_back(cyc);
            end
            if (fire_pop) begin
                del_pc.push_back(ppc);
                del_data.push_back(pdat);
            end
        end
        #1;
        if (mq.size() > 0 && mq[0].due <= cyc + 1) begin
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data  = wordf(mq[0].addr);
        end else begin
            bus.mem_resp_valid = 1'b0;
            bus.mem_resp_data  = 32'h0;
        end
    endtask

    task automatic do_reset();
        reset              = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.mem_req_ready  = 1'b1;
        bus.instr_ready    = 1'b1;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = 32'h0;
        tick();
        tick();
        reset = 1'b1;
        clear_logs();
    endtask

    task automatic wait_del(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (del_pc.size() < n && k < budget) begin
            tick();
            k++;
        end
        if (del_pc.size() < n) check({name, "_timeout"}, del_pc.size(), n);
    endtask

    task automatic check_del(input int i, input logic [31:0] exp_pc, input string name);
        if (del_pc.size() > i) begin
            check({name, "_pc"}, del_pc[i], exp_pc);
            check({name, "_data"}, del_data[i], wordf(exp_pc));
        end else begin
            check({name, "_missing"}, del_pc.size(), i + 1);
        end
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = pc;
        clear_logs();
        tick();
        bus.redirect_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got %0d cycles expected fewer", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int rel;
        int first_v;
        int changes;
        int found;
        int reqs;

        vecs[0] = '{start: 32'h0000_1000, lat: 1, e0: 32'h0000_1000, e1: 32'h0000_1004, e2: 32'h0000_1008};
        vecs[1] = '{start: 32'hFFFF_FFF8, lat: 2, e0: 32'hFFFF_FFF8, e1: 32'hFFFF_FFFC, e2: 32'h0000_0000};
`ifdef FETCH_MISALIGN_TRAP_EN
        vecs[2] = '{start: 32'h0000_0200, lat: 4, e0: 32'h0000_0200, e1: 32'h0000_0204, e2: 32'h0000_0208};
`else
        vecs[2] = '{start: 32'h0000_0203, lat: 4, e0: 32'h0000_0200, e1: 32'h0000_0204, e2: 32'h0000_0208};
`endif
        vecs[3] = '{start: 32'h8000_0010, lat: 3, e0: 32'h8000_0010, e1: 32'h8000_0014, e2: 32'h8000_0018};

        // Reset state
        do_reset();
        reset = 1'b0;
        tick();
        check("rst_mem_req_valid", bus.mem_req_valid, 0);
        check("rst_instr_valid", bus.instr_valid, 0);
        check("rst_instr_out", bus.instr_out, 0);
        check("rst_instr_pc", bus.instr_pc, 0);

        // Boot: latency 1, consumer always ready
        reset = 1'b1;
        clear_logs();
        lat     = 1;
        rel     = cyc;
        first_v = 0;
        for (int k = 0; k < 14; k++) begin
            tick();
            if (first_v == 0 && bus.instr_valid) first_v = cyc - rel;
        end
        check("boot_first_valid_cycle", first_v, 3);
        if (req_addr_log.size() >= 3) begin
            check("boot_first_req_cycle", req_cyc_log[0] - rel, 2);
            check("boot_req0", req_addr_log[0], 32'h0);
            check("boot_req1", req_addr_log[1], 32'h4);
            check("boot_req2", req_addr_log[2], 32'h8);
        end else begin
            check("boot_req_count", req_addr_log.size(), 3);
        end
        check_del(0, 32'h0, "boot_d0");
        check_del(1, 32'h4, "boot_d1");
        check_del(2, 32'h8, "boot_d2");

        // Consumer stalled for 10 cycles: only DEPTH requests, head holds
        do_reset();
        lat             = 1;
        bus.instr_ready = 1'b0;
        changes         = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bus.instr_valid && bus.instr_pc !== 32'h0) changes++;
        end
        check("stall_req_count", req_addr_log.size(), 2);
        check("stall_req_valid", bus.mem_req_valid, 0);
        check("stall_instr_valid", bus.instr_valid, 1);
        check("stall_head_pc", bus.instr_pc, 32'h0);
        check("stall_head_data", bus.instr_out, wordf(32'h0));
        check("stall_head_changes", changes, 0);
        bus.instr_ready = 1'b1;
        wait_del(2, 20, "stall_release");
        check_del(0, 32'h0, "stall_d0");
        check_del(1, 32'h4, "stall_d1");

        // Memory not ready: request address held steady
        do_reset();
        bus.mem_req_ready = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            tick();
            check("hold_req_valid", bus.mem_req_valid, 1);
            check("hold_req_addr", bus.mem_req_addr, 32'h0);
        end
        bus.mem_req_ready = 1'b1;
        wait_del(1, 20, "hold_release");
        check_del(0, 32'h0, "hold_d0");

        // Latency 3, two outstanding, redirect to 0x40
        do_reset();
        lat   = 3;
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            tick();
            if (req_addr_log.size() >= 2) found = 1;
        end
        check("flush_setup_two_req", found, 1);
        redirect_to(32'h0000_0040);
        check("flush_instr_valid_after_redirect", bus.instr_valid, 0);
        check("flush_req_valid_in_flush", bus.mem_req_valid, 0);
        wait_del(1, 40, "flush_resume");
        check_del(0, 32'h40, "flush_d0");
        if (req_addr_log.size() > 0 && resp_cyc_log.size() >= 2) begin
            check("flush_first_req_addr", req_addr_log[0], 32'h40);
            check("flush_req_after_drain", req_cyc_log[0] > resp_cyc_log[1], 1);
        end else begin
            check("flush_log_missing", 0, 1);
        end

        // Redirect in the same cycle as a response and a consumer pop
        do_reset();
        lat   = 1;
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            tick();
            if (bus.instr_valid && bus.mem_resp_valid) found = 1;
        end
        check("race_setup_found", found, 1);
        redirect_to(32'h0000_0100);
        check("race_instr_valid_after_redirect", bus.instr_valid, 0);
        wait_del(2, 30, "race_resume");
        check_del(0, 32'h100, "race_d0");
        check_del(1, 32'h104, "race_d1");

        // Table-driven redirect targets, latencies and address wrap
        for (int v = 0; v < 4; v++) begin
            do_reset();
            lat = vecs[v].lat;
            for (int k = 0; k < 4; k++) tick();
            redirect_to(vecs[v].start);
            wait_del(3, 60, $sformatf("vec%0d", v));
            check_del(0, vecs[v].e0, $sformatf("vec%0d_d0", v));
            check_del(1, vecs[v].e1, $sformatf("vec%0d_d1", v));
            check_del(2, vecs[v].e2, $sformatf("vec%0d_d2", v));
        end

`ifdef FETCH_MISALIGN_TRAP_EN
        // Misaligned redirect traps; aligned redirect clears and resumes
        do_reset();
        lat = 2;
        for (int k = 0; k < 4; k++) tick();
        check("trap_fault_idle", bus.misaligned_fault, 0);
        redirect_to(32'h0000_0042);
        check("trap_fault_set", bus.misaligned_fault, 1);
        check("trap_fault_pc", bus.fault_pc, 32'h42);
        reqs = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (bus.mem_req_valid) reqs++;
        end
        check("trap_no_requests", reqs, 0);
        check("trap_no_delivery", del_pc.size(), 0);
        redirect_to(32'h0000_0080);
        check("trap_fault_cleared", bus.misaligned_fault, 0);
        wait_del(1, 40, "trap_resume");
        check_del(0, 32'h80, "trap_d0");
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
